// File: rtl/hazard_response_unit.sv
// Hazard response: turns the ID-stage hazard vector, stall and branch_taken into PC/IF-ID holds,
// IF/ID flushes, ID/EX bubbles and registered EX forwarding selects, and counts stall cycles.
module hazard_response_unit #(
  parameter int STALL_CYCLES = 1,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [10:0]      haz,
  input  logic             stall,
  input  logic             branch_taken,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic [1:0]       fwd_br_sel,
  output logic [1:0]       fwd_r0_sel,
  output logic [1:0]       fwd_st_sel,
  output logic [CNT_W-1:0] stall_count
);

  localparam int MAX_LEN = (STALL_CYCLES > FLUSH_CYCLES) ? STALL_CYCLES : FLUSH_CYCLES;
  localparam int CW      = $clog2(MAX_LEN + 1);
  localparam logic [CW-1:0] STALL_LOAD = CW'(STALL_CYCLES - 1);
  localparam logic [CW-1:0] FLUSH_LOAD = CW'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_t;

  // state is the observable FSM state for assertions and debug probes.
  state_t        state;
  logic [CW-1:0] cnt;

  function automatic logic [1:0] pick(input logic newer, input logic older);
    if (newer)      pick = 2'b01;
    else if (older) pick = 2'b10;
    else            pick = 2'b00;
  endfunction

  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    if (rst) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (branch_taken) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else begin
      case (state)
        RUN: begin
          if (stall) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_bubble = 1'b1;
          end
        end
        STALL: begin
          pc_en       = 1'b0;
          ifid_en     = 1'b0;
          idex_bubble = 1'b1;
        end
        FLUSH: begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      cnt         <= '0;
      fwd_a_sel   <= 2'b00;
      fwd_b_sel   <= 2'b00;
      fwd_br_sel  <= 2'b00;
      fwd_r0_sel  <= 2'b00;
      fwd_st_sel  <= 2'b00;
      stall_count <= '0;
    end else begin
      // A taken branch overrides any hold in progress and restarts the flush window.
      if (branch_taken) begin
        if (FLUSH_CYCLES > 1) begin
          state <= FLUSH;
          cnt   <= FLUSH_LOAD;
        end else begin
          state <= RUN;
          cnt   <= '0;
        end
      end else begin
        case (state)
          RUN: begin
            if (stall && (STALL_CYCLES > 1)) begin
              state <= STALL;
              cnt   <= STALL_LOAD;
            end
          end
          STALL, FLUSH: begin
            if (cnt <= CW'(1)) begin
              state <= RUN;
              cnt   <= '0;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          default: begin
            state <= RUN;
            cnt   <= '0;
          end
        endcase
      end

      // A bubble entering ID/EX must not carry forwarding selects.
      if (idex_bubble) begin
        fwd_a_sel  <= 2'b00;
        fwd_b_sel  <= 2'b00;
        fwd_br_sel <= 2'b00;
        fwd_r0_sel <= 2'b00;
        fwd_st_sel <= 2'b00;
      end else begin
        fwd_a_sel  <= pick(haz[1], haz[0]);
        fwd_b_sel  <= pick(haz[2], haz[3]);
        fwd_br_sel <= pick(haz[4], haz[5]);
        fwd_r0_sel <= pick(haz[6], haz[7]);
        if (haz[10])     fwd_st_sel <= 2'b01;
        else if (haz[8]) fwd_st_sel <= 2'b10;
        else if (haz[9]) fwd_st_sel <= 2'b11;
        else             fwd_st_sel <= 2'b00;
      end

      if (!pc_en && (stall_count != {CNT_W{1'b1}}))
        stall_count <= stall_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_response_unit.sv
// Bench for hazard_response_unit: two parameterisations driven in lockstep, per-cycle expected
// outputs from a remaining-cycles reference model, checked by a negedge monitor.
module tb_hazard_response_unit;

  localparam int W = 30;  // {pc_en, ifid_en, ifid_flush, idex_bubble, fwd[9:0], count[15:0]}

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [10:0] haz = '0;

  logic        pc_en_a, ifid_en_a, ifid_flush_a, idex_bubble_a;
  logic [1:0]  fa_a, fb_a, fbr_a, fr0_a, fst_a;
  logic [15:0] stall_count_a;
  logic        pc_en_b, ifid_en_b, ifid_flush_b, idex_bubble_b;
  logic [1:0]  fa_b, fb_b, fbr_b, fr0_b, fst_b;
  logic [3:0]  stall_count_b;

  always #5 clk = ~clk;

  hazard_response_unit #(.STALL_CYCLES(3), .FLUSH_CYCLES(2), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .haz(haz), .stall(stall), .branch_taken(branch_taken),
    .pc_en(pc_en_a), .ifid_en(ifid_en_a), .ifid_flush(ifid_flush_a), .idex_bubble(idex_bubble_a),
    .fwd_a_sel(fa_a), .fwd_b_sel(fb_a), .fwd_br_sel(fbr_a), .fwd_r0_sel(fr0_a),
    .fwd_st_sel(fst_a), .stall_count(stall_count_a)
  );

  hazard_response_unit #(.STALL_CYCLES(4), .FLUSH_CYCLES(1), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .haz(haz), .stall(stall), .branch_taken(branch_taken),
    .pc_en(pc_en_b), .ifid_en(ifid_en_b), .ifid_flush(ifid_flush_b), .idex_bubble(idex_bubble_b),
    .fwd_a_sel(fa_b), .fwd_b_sel(fb_b), .fwd_br_sel(fbr_b), .fwd_r0_sel(fr0_b),
    .fwd_st_sel(fst_b), .stall_count(stall_count_b)
  );

  // Reference model: per instance, how many hold/flush cycles remain after the current one.
  int          p_stall[2] = '{3, 4};
  int          p_flush[2] = '{2, 1};
  int          p_cmax[2]  = '{65535, 15};
  int          m_stall_left[2] = '{0, 0};
  int          m_flush_left[2] = '{0, 0};
  int          m_count[2] = '{0, 0};
  logic [9:0]  m_fwd[2] = '{10'd0, 10'd0};

  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];
  int tests = 0;
  int fails = 0;

  function automatic logic [9:0] ref_fwd(input logic [10:0] h);
    logic [1:0] a, b, br, r0, st;
    a  = h[1] ? 2'd1 : (h[0] ? 2'd2 : 2'd0);
    b  = h[2] ? 2'd1 : (h[3] ? 2'd2 : 2'd0);
    br = h[4] ? 2'd1 : (h[5] ? 2'd2 : 2'd0);
    r0 = h[6] ? 2'd1 : (h[7] ? 2'd2 : 2'd0);
    st = h[10] ? 2'd1 : (h[8] ? 2'd2 : (h[9] ? 2'd3 : 2'd0));
    return {a, b, br, r0, st};
  endfunction

  task automatic model_step(input int i, input logic r, input logic s, input logic b,
                            input logic [10:0] h, output logic [W-1:0] v);
    logic [3:0] ctrl;
    if (r)                        ctrl = 4'b0011;
    else if (b)                   ctrl = 4'b1111;
    else if (m_flush_left[i] > 0) ctrl = 4'b1111;
    else if (m_stall_left[i] > 0 || s) ctrl = 4'b0001;
    else                          ctrl = 4'b1100;
    v = {ctrl, m_fwd[i], 16'(m_count[i])};
    if (r) begin
      m_stall_left[i] = 0;
      m_flush_left[i] = 0;
      m_count[i]      = 0;
      m_fwd[i]        = '0;
    end else begin
      if (b) begin
        m_flush_left[i] = p_flush[i] - 1;
        m_stall_left[i] = 0;
      end else if (m_flush_left[i] > 0) begin
        m_flush_left[i]--;
      end else if (m_stall_left[i] > 0) begin
        m_stall_left[i]--;
      end else if (s) begin
        m_stall_left[i] = p_stall[i] - 1;
      end
      m_fwd[i] = ctrl[0] ? 10'd0 : ref_fwd(h);
      if (!ctrl[3] && m_count[i] < p_cmax[i]) m_count[i]++;
    end
  endtask

  task automatic drive(input logic r, input logic s, input logic b, input logic [10:0] h);
    logic [W-1:0] v;
    @(posedge clk);
    #1;
    rst = r; stall = s; branch_taken = b; haz = h;
    model_step(0, r, s, b, h, v);
    exp_q0.push_back(v);
    model_step(1, r, s, b, h, v);
    exp_q1.push_back(v);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 1'b0, 1'b0, 11'h000);
  endtask

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act[29:26] !== exp[29:26]) begin
      fails++;
      $display("FAIL %s ctrl t=%0t got %b expected %b", name, $time, act[29:26], exp[29:26]);
    end
    tests++;
    if (act[25:16] !== exp[25:16]) begin
      fails++;
      $display("FAIL %s fwd t=%0t got %h expected %h", name, $time, act[25:16], exp[25:16]);
    end
    tests++;
    if (act[15:0] !== exp[15:0]) begin
      fails++;
      $display("FAIL %s stall_count t=%0t got %0d expected %0d", name, $time, act[15:0], exp[15:0]);
    end
  endtask

  // Monitor: every cycle the DUTs present a full output set; compare against the queued expectation.
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (exp_q0.size() > 0) begin
      e = exp_q0.pop_front();
      check("dut_a", {pc_en_a, ifid_en_a, ifid_flush_a, idex_bubble_a,
                      fa_a, fb_a, fbr_a, fr0_a, fst_a, stall_count_a}, e);
    end
    if (exp_q1.size() > 0) begin
      e = exp_q1.pop_front();
      check("dut_b", {pc_en_b, ifid_en_b, ifid_flush_b, idex_bubble_b,
                      fa_b, fb_b, fbr_b, fr0_b, fst_b, 12'd0, stall_count_b}, e);
    end
  end

  initial begin
    // First reset cycle establishes known state; checking starts on the second.
    @(posedge clk);
    #1;
    rst = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 11'h000);
    idle(3);

    drive(1'b0, 1'b0, 1'b0, 11'h003);
    drive(1'b0, 1'b0, 1'b0, 11'h008);
    drive(1'b0, 1'b0, 1'b0, 11'h700);
    idle(2);

    drive(1'b0, 1'b1, 1'b0, 11'h700);
    idle(6);

    drive(1'b0, 1'b1, 1'b1, 11'h0ff);
    idle(4);

    drive(1'b0, 1'b1, 1'b0, 11'h000);
    drive(1'b0, 1'b0, 1'b1, 11'h7ff);
    idle(5);

    drive(1'b0, 1'b0, 1'b1, 11'h000);
    drive(1'b0, 1'b0, 1'b1, 11'h555);
    drive(1'b0, 1'b1, 1'b0, 11'h2aa);
    idle(6);

    for (int k = 0; k < 22; k++) drive(1'b0, 1'b1, 1'b0, 11'(k * 93));
    idle(1);
    @(negedge clk);
    #1;
    tests++;
    if (stall_count_b !== 4'hf) begin
      fails++;
      $display("FAIL saturation dut_b stall_count got %0d expected 15", stall_count_b);
    end

    for (int k = 0; k < 1500; k++) begin
      drive(($urandom_range(0, 199) == 0),
            ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 7) == 0),
            11'($urandom_range(0, 2047)));
    end
    idle(2);

    for (int k = 0; k < 10 && (exp_q0.size() > 0 || exp_q1.size() > 0); k++) @(negedge clk);
    #1;
    if (exp_q0.size() > 0 || exp_q1.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain queues left %0d/%0d expected 0", exp_q0.size(), exp_q1.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
